bank_req_arbiter: RTL and testbench



---
 rtl/bank_req_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_bank_req_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bank_req_arbiter.sv
// bank_req_arbiter
//   Round-robin arbiter that shares one bank's HTU request port among three
//   channel request streams. It has a single registered output stage with a
//   valid/allowIn handshake. A granted payload stays stable until the bank
//   takes it.
//
//   Optional build macro: MCASH_ARB_PERF_CNT_EN adds saturating 16-bit
//   per-channel grant counters and a stall counter.
//
// Ports
//   clk_i, rst_i              clock; asynchronous active-high reset
//   chN_req_valid_i           channel N has a request for this bank (N=0..2)
//   chN_req_allowIn_o         channel N request accepted this cycle
//   chN_req_opcode_i          channel N opcode
//   chN_req_addr_i            channel N line address [31:4]
//   chN_req_wbuffer_id_i      channel N write-buffer id
//   htu_valid_o               output stage holds a request
//   htu_allowIn_i             bank HTU can accept
//   htu_ch_id_o               winning channel index (0..2)
//   htu_opcode_o / htu_addr_o / htu_wbuffer_id_o   registered payload
//   perf_grant_cnt_chN_o      (macro only) grants given to channel N
//   perf_stall_cnt_o          (macro only) cycles held while the bank stalls
module bank_req_arbiter #(
   parameter int unsigned NUM_CH = 3,
   parameter int unsigned WBID_W = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              ch0_req_valid_i,
   output logic              ch0_req_allowIn_o,
   input  logic [1:0]        ch0_req_opcode_i,
   input  logic [31:4]       ch0_req_addr_i,
   input  logic [WBID_W-1:0] ch0_req_wbuffer_id_i,
   input  logic              ch1_req_valid_i,
   output logic              ch1_req_allowIn_o,
   input  logic [1:0]        ch1_req_opcode_i,
   input  logic [31:4]       ch1_req_addr_i,
   input  logic [WBID_W-1:0] ch1_req_wbuffer_id_i,
   input  logic              ch2_req_valid_i,
   output logic              ch2_req_allowIn_o,
   input  logic [1:0]        ch2_req_opcode_i,
   input  logic [31:4]       ch2_req_addr_i,
   input  logic [WBID_W-1:0] ch2_req_wbuffer_id_i,
   output logic              htu_valid_o,
   input  logic              htu_allowIn_i,
   output logic [1:0]        htu_ch_id_o,
   output logic [1:0]        htu_opcode_o,
   output logic [31:4]       htu_addr_o,
   output logic [WBID_W-1:0] htu_wbuffer_id_o
`ifdef MCASH_ARB_PERF_CNT_EN
   ,
   output logic [15:0]       perf_grant_cnt_ch0_o,
   output logic [15:0]       perf_grant_cnt_ch1_o,
   output logic [15:0]       perf_grant_cnt_ch2_o,
   output logic [15:0]       perf_stall_cnt_o
`endif
);

   logic [NUM_CH-1:0] req;
   logic [NUM_CH-1:0] grant;
   logic              load_en;
   logic              any_grant;
   logic [1:0]        win_idx;
   logic [1:0]        rr_q;

   logic [1:0]        sel_opcode;
   logic [31:4]       sel_addr;
   logic [WBID_W-1:0] sel_wbid;

   logic              htu_valid_q;
   logic [1:0]        htu_ch_id_q;
   logic [1:0]        htu_opcode_q;
   logic [31:4]       htu_addr_q;
   logic [WBID_W-1:0] htu_wbid_q;

   assign req     = {ch2_req_valid_i, ch1_req_valid_i, ch0_req_valid_i};
   // The stage can take a new request when empty or when its current one leaves.
   assign load_en = ~htu_valid_q | htu_allowIn_i;

   // Search starts just after the last winner: rr_q+1, rr_q+2, rr_q+3 (mod 3).
   always_comb begin
      grant = '0;
      case (rr_q)
         2'd0: begin
            if (req[1])      grant = 3'b010;
            else if (req[2]) grant = 3'b100;
            else if (req[0]) grant = 3'b001;
         end
         2'd1: begin
            if (req[2])      grant = 3'b100;
            else if (req[0]) grant = 3'b001;
            else if (req[1]) grant = 3'b010;
         end
         default: begin
            if (req[0])      grant = 3'b001;
            else if (req[1]) grant = 3'b010;
            else if (req[2]) grant = 3'b100;
         end
      endcase
      if (!load_en) grant = '0;
   end

   assign any_grant = |grant;

   always_comb begin
      if (grant[2])      win_idx = 2'd2;
      else if (grant[1]) win_idx = 2'd1;
      else               win_idx = 2'd0;
   end

   assign ch0_req_allowIn_o = grant[0];
   assign ch1_req_allowIn_o = grant[1];
   assign ch2_req_allowIn_o = grant[2];

   always_comb begin
      case (win_idx)
         2'd1: begin
            sel_opcode = ch1_req_opcode_i;
            sel_addr   = ch1_req_addr_i;
            sel_wbid   = ch1_req_wbuffer_id_i;
         end
         2'd2: begin
            sel_opcode = ch2_req_opcode_i;
            sel_addr   = ch2_req_addr_i;
            sel_wbid   = ch2_req_wbuffer_id_i;
         end
         default: begin
            sel_opcode = ch0_req_opcode_i;
            sel_addr   = ch0_req_addr_i;
            sel_wbid   = ch0_req_wbuffer_id_i;
         end
      endcase
   end

   // rr_q starts at 2 so channel 0 has first priority out of reset. When the
   // stage is stalled load_en is low, so both payload and rr_q hold.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         htu_valid_q  <= 1'b0;
         htu_ch_id_q  <= 2'd0;
         htu_opcode_q <= 2'd0;
         htu_addr_q   <= '0;
         htu_wbid_q   <= '0;
         rr_q         <= 2'd2;
      end else if (load_en) begin
         htu_valid_q <= any_grant;
         if (any_grant) begin
            htu_ch_id_q  <= win_idx;
            htu_opcode_q <= sel_opcode;
            htu_addr_q   <= sel_addr;
            htu_wbid_q   <= sel_wbid;
            rr_q         <= win_idx;
         end
      end
   end

   assign htu_valid_o      = htu_valid_q;
   assign htu_ch_id_o      = htu_ch_id_q;
   assign htu_opcode_o     = htu_opcode_q;
   assign htu_addr_o       = htu_addr_q;
   assign htu_wbuffer_id_o = htu_wbid_q;

`ifdef MCASH_ARB_PERF_CNT_EN
   logic [15:0] grant_cnt_q [3];
   logic [15:0] stall_cnt_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int n = 0; n < 3; n++) grant_cnt_q[n] <= 16'd0;
         stall_cnt_q <= 16'd0;
      end else begin
         for (int n = 0; n < 3; n++) begin
            if (grant[n] && (grant_cnt_q[n] != 16'hFFFF)) begin
               grant_cnt_q[n] <= grant_cnt_q[n] + 16'd1;
            end
         end
         if (htu_valid_q && !htu_allowIn_i && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
         end
      end
   end

   assign perf_grant_cnt_ch0_o = grant_cnt_q[0];
   assign perf_grant_cnt_ch1_o = grant_cnt_q[1];
   assign perf_grant_cnt_ch2_o = grant_cnt_q[2];
   assign perf_stall_cnt_o     = stall_cnt_q;
`endif

endmodule

// File: tb/tb_bank_req_arbiter.sv
// tb_bank_req_arbiter
//   Self-checking bench for bank_req_arbiter: directed scenarios plus a
//   randomized run against a round-robin reference model.
//   Define MCASH_ARB_PERF_CNT_EN to also cover the performance counters.
module tb_bank_req_arbiter;

   logic        clk;
   logic        rst;
   logic [2:0]  v;
   logic [1:0]  op   [3];
   logic [27:0] addr [3];
   logic [7:0]  wb   [3];
   logic        allow;
   logic [2:0]  ai;
   logic        htu_valid;
   logic [1:0]  htu_ch_id;
   logic [1:0]  htu_op;
   logic [27:0] htu_addr;
   logic [7:0]  htu_wb;
`ifdef MCASH_ARB_PERF_CNT_EN
   logic [15:0] pc0, pc1, pc2, pstall;
`endif

   int checks = 0;
   int errors = 0;

   // Reference model state
   bit          m_valid;
   int          m_ch;
   int          m_last;
   logic [1:0]  m_op;
   logic [27:0] m_addr;
   logic [7:0]  m_wb;

   bank_req_arbiter #(.NUM_CH(3), .WBID_W(8)) dut (
      .clk_i                (clk),
      .rst_i                (rst),
      .ch0_req_valid_i      (v[0]),
      .ch0_req_allowIn_o    (ai[0]),
      .ch0_req_opcode_i     (op[0]),
      .ch0_req_addr_i       (addr[0]),
      .ch0_req_wbuffer_id_i (wb[0]),
      .ch1_req_valid_i      (v[1]),
      .ch1_req_allowIn_o    (ai[1]),
      .ch1_req_opcode_i     (op[1]),
      .ch1_req_addr_i       (addr[1]),
      .ch1_req_wbuffer_id_i (wb[1]),
      .ch2_req_valid_i      (v[2]),
      .ch2_req_allowIn_o    (ai[2]),
      .ch2_req_opcode_i     (op[2]),
      .ch2_req_addr_i       (addr[2]),
      .ch2_req_wbuffer_id_i (wb[2]),
      .htu_valid_o          (htu_valid),
      .htu_allowIn_i        (allow),
      .htu_ch_id_o          (htu_ch_id),
      .htu_opcode_o         (htu_op),
      .htu_addr_o           (htu_addr),
      .htu_wbuffer_id_o     (htu_wb)
`ifdef MCASH_ARB_PERF_CNT_EN
      ,
      .perf_grant_cnt_ch0_o (pc0),
      .perf_grant_cnt_ch1_o (pc1),
      .perf_grant_cnt_ch2_o (pc2),
      .perf_stall_cnt_o     (pstall)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clear_inputs();
      v     = 3'b000;
      allow = 1'b0;
      for (int n = 0; n < 3; n++) begin
         op[n]   = 2'd0;
         addr[n] = 28'd0;
         wb[n]   = 8'd0;
      end
   endtask

   task automatic set_ch(input int n, input logic [1:0] o, input logic [27:0] a,
                         input logic [7:0] w);
      v[n]    = 1'b1;
      op[n]   = o;
      addr[n] = a;
      wb[n]   = w;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_inputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst     = 1'b0;
      m_valid = 1'b0;
      m_ch    = 0;
      m_last  = 2;
      m_op    = 2'd0;
      m_addr  = 28'd0;
      m_wb    = 8'd0;
   endtask

   // Winner under the round-robin rule, or -1 if nothing is granted.
   function automatic int model_pick();
      int idx;
      if (m_valid && !allow) return -1;
      for (int k = 1; k <= 3; k++) begin
         idx = (m_last + k) % 3;
         if (v[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic model_tick();
      int  w;
      bit  le;
      w  = model_pick();
      le = !m_valid || allow;
      @(posedge clk);
      #1;
      if (le) begin
         if (w >= 0) begin
            m_valid = 1'b1;
            m_ch    = w;
            m_op    = op[w];
            m_addr  = addr[w];
            m_wb    = wb[w];
            m_last  = w;
         end else begin
            m_valid = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clear_inputs();
      #3;
      checks++;
      if (htu_valid !== 1'b0 || htu_ch_id !== 2'd0 || htu_op !== 2'd0 ||
          htu_addr !== 28'd0 || htu_wb !== 8'd0) begin
         errors++;
         $display("FAIL reset_outputs: got v=%b id=%0d op=%0d a=%h wb=%h want all zero",
                  htu_valid, htu_ch_id, htu_op, htu_addr, htu_wb);
      end
      checks++;
      if (ai !== 3'b000) begin
         errors++;
         $display("FAIL reset_allowIn: got %b want 000", ai);
      end
      do_reset();
   endtask

   task automatic test_single_ch1();
      do_reset();
      set_ch(1, 2'd2, 28'h1234567, 8'h5A);
      allow = 1'b1;
      #1;
      checks++;
      if (ai !== 3'b010) begin
         errors++;
         $display("FAIL single_allowIn: got %b want 010", ai);
      end
      @(posedge clk);
      #1;
      checks++;
      if (htu_valid !== 1'b1 || htu_ch_id !== 2'd1 || htu_addr !== 28'h1234567 ||
          htu_op !== 2'd2 || htu_wb !== 8'h5A) begin
         errors++;
         $display("FAIL single_payload: got v=%b id=%0d a=%h op=%0d wb=%h want 1 1 1234567 2 5a",
                  htu_valid, htu_ch_id, htu_addr, htu_op, htu_wb);
      end
      @(negedge clk);
      v = 3'b000;
   endtask

   task automatic test_fairness();
      logic [2:0] want;
      do_reset();
      for (int n = 0; n < 3; n++) set_ch(n, 2'(n), 28'(32'h100 + n), 8'(8'h10 + n));
      allow = 1'b1;
      for (int i = 0; i < 9; i++) begin
         #1;
         want = 3'b001 << (i % 3);
         checks++;
         if (ai !== want) begin
            errors++;
            $display("FAIL fair_grant[%0d]: got %b want %b", i, ai, want);
         end
         @(posedge clk);
         #1;
         checks++;
         if (htu_valid !== 1'b1 || htu_ch_id !== 2'(i % 3) ||
             htu_addr !== 28'(32'h100 + i % 3)) begin
            errors++;
            $display("FAIL fair_out[%0d]: got v=%b id=%0d a=%h want 1 %0d %h", i, htu_valid,
                     htu_ch_id, htu_addr, i % 3, 32'h100 + i % 3);
         end
         @(negedge clk);
      end
      v = 3'b000;
   endtask

   task automatic test_stall();
      do_reset();
      set_ch(0, 2'd1, 28'hABCDEF0, 8'hC3);
      allow = 1'b1;
      @(posedge clk);
      @(negedge clk);
      v = 3'b000;
      set_ch(1, 2'd2, 28'h1111111, 8'h11);
      set_ch(2, 2'd3, 28'h2222222, 8'h22);
      allow = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if (ai !== 3'b000) begin
            errors++;
            $display("FAIL stall_allowIn[%0d]: got %b want 000", i, ai);
         end
         @(posedge clk);
         #1;
         checks++;
         if (htu_valid !== 1'b1 || htu_ch_id !== 2'd0 || htu_addr !== 28'hABCDEF0 ||
             htu_op !== 2'd1 || htu_wb !== 8'hC3) begin
            errors++;
            $display("FAIL stall_hold[%0d]: got v=%b id=%0d a=%h op=%0d wb=%h want 1 0 abcdef0 1 c3",
                     i, htu_valid, htu_ch_id, htu_addr, htu_op, htu_wb);
         end
         @(negedge clk);
      end
      allow = 1'b1;
      #1;
      checks++;
      if (ai !== 3'b010) begin
         errors++;
         $display("FAIL stall_release_grant: got %b want 010", ai);
      end
      @(posedge clk);
      #1;
      checks++;
      if (htu_valid !== 1'b1 || htu_ch_id !== 2'd1 || htu_addr !== 28'h1111111) begin
         errors++;
         $display("FAIL stall_release_out: got v=%b id=%0d a=%h want 1 1 1111111",
                  htu_valid, htu_ch_id, htu_addr);
      end
      @(negedge clk);
      v = 3'b000;
   endtask

   task automatic test_rr_after_ch2();
      do_reset();
      set_ch(2, 2'd0, 28'h0000222, 8'h02);
      allow = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (ai !== 3'b100) begin
            errors++;
            $display("FAIL rr_ch2_only[%0d]: got %b want 100", i, ai);
         end
         @(negedge clk);
      end
      set_ch(0, 2'd0, 28'h0000111, 8'h01);
      #1;
      checks++;
      if (ai !== 3'b001) begin
         errors++;
         $display("FAIL rr_ch0_next: got %b want 001", ai);
      end
      @(negedge clk);
      v = 3'b000;
   endtask

   task automatic test_async_reset();
      do_reset();
      set_ch(0, 2'd3, 28'h0000AAA, 8'hAA);
      allow = 1'b1;
      @(posedge clk);
      @(negedge clk);
      v = 3'b000;
      set_ch(1, 2'd1, 28'h0000BBB, 8'hBB);
      allow = 1'b0;
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (htu_valid !== 1'b0) begin
         errors++;
         $display("FAIL async_reset_valid: got %b want 0", htu_valid);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int n = 0; n < 3; n++) set_ch(n, 2'd0, 28'(n), 8'(n));
      allow = 1'b1;
      #1;
      checks++;
      if (ai !== 3'b001) begin
         errors++;
         $display("FAIL async_reset_first_grant: got %b want 001", ai);
      end
      @(negedge clk);
      v = 3'b000;
   endtask

   task automatic test_random();
      int         e;
      logic [2:0] want;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         for (int n = 0; n < 3; n++) begin
            v[n]    = ($urandom_range(0, 99) < 55);
            op[n]   = 2'($urandom);
            addr[n] = 28'($urandom);
            wb[n]   = 8'($urandom);
         end
         allow = ($urandom_range(0, 99) < 65);
         #1;
         e    = model_pick();
         want = (e >= 0) ? (3'b001 << e) : 3'b000;
         checks++;
         if (ai !== want) begin
            errors++;
            $display("FAIL rand_allowIn[%0d]: got %b want %b", i, ai, want);
         end
         model_tick();
         checks++;
         if (htu_valid !== m_valid) begin
            errors++;
            $display("FAIL rand_valid[%0d]: got %b want %b", i, htu_valid, m_valid);
         end else if (m_valid) begin
            checks++;
            if (htu_ch_id !== 2'(m_ch) || htu_op !== m_op || htu_addr !== m_addr ||
                htu_wb !== m_wb) begin
               errors++;
               $display("FAIL rand_payload[%0d]: got id=%0d op=%0d a=%h wb=%h want %0d %0d %h %h",
                        i, htu_ch_id, htu_op, htu_addr, htu_wb, m_ch, m_op, m_addr, m_wb);
            end
         end
         @(negedge clk);
      end
      v = 3'b000;
   endtask

`ifdef MCASH_ARB_PERF_CNT_EN
   task automatic test_perf();
      do_reset();
      checks++;
      if (pc0 !== 16'd0 || pc1 !== 16'd0 || pc2 !== 16'd0 || pstall !== 16'd0) begin
         errors++;
         $display("FAIL perf_reset: got %h %h %h %h want 0 0 0 0", pc0, pc1, pc2, pstall);
      end
      set_ch(0, 2'd0, 28'h0000123, 8'h00);
      allow = 1'b1;
      repeat (70000) @(posedge clk);
      @(negedge clk);
      checks++;
      if (pc0 !== 16'hFFFF || pc1 !== 16'd0) begin
         errors++;
         $display("FAIL perf_grant_sat: got ch0=%h ch1=%h want ffff 0000", pc0, pc1);
      end
      allow = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (pstall !== 16'd4) begin
         errors++;
         $display("FAIL perf_stall: got %0d want 4", pstall);
      end
      @(negedge clk);
      allow = 1'b1;
      v     = 3'b000;
   endtask
`endif

   initial begin
      rst = 1'b1;
      clear_inputs();
      test_reset();
      test_single_ch1();
      test_fairness();
      test_stall();
      test_rr_after_ch2();
      test_async_reset();
      test_random();
`ifdef MCASH_ARB_PERF_CNT_EN
      test_perf();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
